// File: rtl/cube_scan_driver_if.sv
`timescale 1ns/1ps
// Frame-source and cube-hardware signals of the layer scan driver, bundled so
// that the frame source side and the display side travel together.
interface cube_scan_driver_if;
    logic         en;
    logic [511:0] frame_in;
    logic         frame_valid;
    logic         frame_swap;
    logic [7:0]   high_csn;
    logic [7:0]   row;
    logic [7:0]   row_cs;
    logic [2:0]   layer;

    // Whoever supplies frames and the enable.
    modport master (
        output en, frame_in, frame_valid,
        input  frame_swap, high_csn, row, row_cs, layer
    );

    // The scan driver itself.
    modport slave (
        input  en, frame_in, frame_valid,
        output frame_swap, high_csn, row, row_cs, layer
    );
endinterface

// File: rtl/cube_scan_driver.sv
`timescale 1ns/1ps
// cube_scan_driver: multiplexes a double-buffered 512-bit frame onto an 8x8x8
// LED cube, one layer at a time. For each layer the eight row bytes are loaded
// into the row latches (data set up one tick, latch enable the next), then the
// layer select is pulled low for ON_TICKS ticks. A pending frame is committed
// to the display buffer only when the last layer of a sweep finishes.
module cube_scan_driver #(
    parameter int SCAN_CLK_DIV = 14,
    parameter int ON_TICKS     = 8
) (
    input  logic               clk,
    input  logic               resetn,
    cube_scan_driver_if.slave  bus
);
    localparam int              ON_W    = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;
    localparam logic [ON_W-1:0] ON_LAST = ON_W'(ON_TICKS - 1);

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

    logic [SCAN_CLK_DIV-1:0] div_reg;
    logic                    tick;

    state_t          state_reg,    state_next;
    logic [2:0]      layer_reg,    layer_next;
    logic [2:0]      row_idx_reg,  row_idx_next;
    logic [ON_W-1:0] on_cnt_reg,   on_cnt_next;
    logic [7:0]      high_csn_reg, high_csn_next;
    logic [7:0]      row_reg,      row_next;
    logic [7:0]      row_cs_reg,   row_cs_next;
    logic            swap_reg;
    logic            do_swap;

    logic [511:0]    disp_reg;
    logic [511:0]    pend_reg;
    logic            pend_flag_reg;

    // Display buffer viewed as 64 row bytes, addressed by {layer, row}.
    logic [7:0]      disp_bytes [64];

    for (genvar gi = 0; gi < 64; gi++) begin : g_disp_bytes
        assign disp_bytes[gi] = disp_reg[gi*8 +: 8];
    end

    assign tick = &div_reg;

    assign bus.high_csn   = high_csn_reg;
    assign bus.row        = row_reg;
    assign bus.row_cs     = row_cs_reg;
    assign bus.layer      = layer_reg;
    assign bus.frame_swap = swap_reg;

    // Free-running scan divider; keeps counting while the scan is disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + SCAN_CLK_DIV'(1);
        end
    end

    // Next scan position and next output values; outputs only change on a
    // tick, except that a low enable parks everything on the very next clk.
    always_comb begin
        state_next    = state_reg;
        layer_next    = layer_reg;
        row_idx_next  = row_idx_reg;
        on_cnt_next   = on_cnt_reg;
        high_csn_next = high_csn_reg;
        row_next      = row_reg;
        row_cs_next   = row_cs_reg;
        do_swap       = 1'b0;

        if (!bus.en) begin
            state_next    = ST_BLANK;
            layer_next    = 3'd0;
            row_idx_next  = 3'd0;
            on_cnt_next   = '0;
            high_csn_next = 8'hFF;
            row_next      = 8'h00;
            row_cs_next   = 8'h00;
        end else if (tick) begin
            case (state_reg)
                ST_BLANK: begin
                    state_next    = ST_SETUP;
                    row_idx_next  = 3'd0;
                    row_next      = disp_bytes[{layer_reg, 3'd0}];
                    row_cs_next   = 8'h00;
                    high_csn_next = 8'hFF;
                end
                ST_SETUP: begin
                    // Data has been stable for a full tick; open the latch.
                    state_next  = ST_STROBE;
                    row_cs_next = 8'd1 << row_idx_reg;
                end
                ST_STROBE: begin
                    row_cs_next = 8'h00;
                    if (row_idx_reg == 3'd7) begin
                        state_next    = ST_SHOW;
                        on_cnt_next   = '0;
                        high_csn_next = ~(8'd1 << layer_reg);
                    end else begin
                        state_next   = ST_SETUP;
                        row_idx_next = row_idx_reg + 3'd1;
                        row_next     = disp_bytes[{layer_reg, row_idx_reg + 3'd1}];
                    end
                end
                ST_SHOW: begin
                    if (on_cnt_reg == ON_LAST) begin
                        state_next    = ST_BLANK;
                        layer_next    = layer_reg + 3'd1;
                        on_cnt_next   = '0;
                        high_csn_next = 8'hFF;
                        // End of the full cube: commit a waiting frame.
                        do_swap       = (layer_reg == 3'd7) && pend_flag_reg;
                    end else begin
                        on_cnt_next = on_cnt_reg + ON_W'(1);
                    end
                end
                default: begin
                    state_next    = ST_BLANK;
                    high_csn_next = 8'hFF;
                    row_cs_next   = 8'h00;
                end
            endcase
        end
    end

    // Scan position and registered cube outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_BLANK;
            layer_reg    <= 3'd0;
            row_idx_reg  <= 3'd0;
            on_cnt_reg   <= '0;
            high_csn_reg <= 8'hFF;
            row_reg      <= 8'h00;
            row_cs_reg   <= 8'h00;
        end else begin
            state_reg    <= state_next;
            layer_reg    <= layer_next;
            row_idx_reg  <= row_idx_next;
            on_cnt_reg   <= on_cnt_next;
            high_csn_reg <= high_csn_next;
            row_reg      <= row_next;
            row_cs_reg   <= row_cs_next;
        end
    end

    // Frame double buffer: capture always works; a capture coinciding with a
    // commit lands in pending while display takes the previous pending frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp_reg      <= '0;
            pend_reg      <= '0;
            pend_flag_reg <= 1'b0;
            swap_reg      <= 1'b0;
        end else begin
            if (do_swap) begin
                disp_reg <= pend_reg;
            end
            if (bus.frame_valid) begin
                pend_reg <= bus.frame_in;
            end
            pend_flag_reg <= bus.frame_valid | (pend_flag_reg & ~do_swap);
            swap_reg      <= do_swap;
        end
    end
endmodule

// File: doc/cube_scan_driver.md
Name: cube_scan_driver

Overview:
Downstream display stage of the 8x8x8 light cube. Takes a complete 512-bit frame from the frame source (UART receiver / pattern generator mux) and multiplexes it onto the cube hardware one layer at a time. Drives the row data bus, the eight row-latch enables (74HC573 LE, active-high) and the eight active-low layer selects. Frame updates are double-buffered, so a new frame only takes effect at a full-cube boundary.

Parameters:
SCAN_CLK_DIV, 14, scan tick period = 2**SCAN_CLK_DIV clk cycles (free-running SCAN_CLK_DIV-bit divider; tick when it is all ones)
ON_TICKS, 8, ticks a loaded layer stays lit (>=1)

Ports:
clk  input  1  system clock, 100 MHz
resetn  input  1  asynchronous active-low reset
en  input  1  scan enable; low = cube dark and scan parked
frame_in  input  512  frame; bit index = layer*64 + row*8 + col
frame_valid  input  1  one-cycle strobe; captures frame_in into pending buffer
frame_swap  output  1  one-cycle pulse when pending buffer is copied to display buffer
high_csn  output  8  layer select, active-low, at most one bit low
row  output  8  row data byte, active-high LED on
row_cs  output  8  row latch enables, active-high, at most one bit high
layer  output  3  layer currently being loaded or shown

Behaviour:
- Reset (async, resetn=0): high_csn=8'hFF, row=0, row_cs=0, layer=0, frame_swap=0, divider=0, display and pending buffers=0, pending flag=0, state=BLANK, row index=0, on counter=0.
- All outputs registered. State advances only on tick cycles, except frame capture and en handling, which act every clk.
- FSM per layer L:
  - BLANK: 1 tick. high_csn=FF, row_cs=0. -> SETUP with row index r=0.
  - SETUP: 1 tick. row=disp[L*64+r*8 +:8], row_cs=0. -> STROBE.
  - STROBE: 1 tick. row held, row_cs=(1<<r). r<7 -> SETUP with r+1; r=7 -> SHOW.
  - SHOW: ON_TICKS ticks. row_cs=0, high_csn=~(1<<L). Then -> BLANK with L+1 (wrap 7->0).
- Layer period = 17+ON_TICKS ticks. Full cube = 8x that.
- Frame capture: frame_valid=1 -> pending<=frame_in and flag<=1. A later frame_valid before the swap overwrites pending (last wins).
- Swap: on the tick leaving SHOW of layer 7, if flag=1: disp<=pending, flag<=0, frame_swap=1 for exactly that clk. The new frame is first visible in layer 0 of the next sweep. If flag=0, there is no swap and no pulse.
- frame_valid on the swap clk: disp takes the old pending value; pending takes the new value; flag stays 1.
- en=0, any clk: next clk high_csn=FF, row_cs=0, row=0, state=BLANK, L=0, r=0. Capture still works. Swap is suppressed while en=0.
- en rising: scan restarts at BLANK of layer 0 on the next tick. Divider keeps running (not reset).
- Invariants: a layer is never lit while any row_cs is high; row never changes in the same tick that its row_cs is high.

Test Plan:
- Reset/idle (SCAN_CLK_DIV=2, ON_TICKS=4): hold resetn=0, then release with en=0 -> high_csn=FF, row_cs=0, row=0, layer=0 indefinitely; frame_swap never pulses.
- Single frame: en=1, frame_valid with frame_in[L*64+r*8+:8]=8'h10*L+r -> frame_swap pulse after the first layer-7 SHOW. Next sweep: each STROBE shows row=10*L+r with row_cs=1<<r. SHOW has high_csn=~(1<<L) for 4 ticks = 16 clk. Layer period = 21 ticks = 84 clk.
- Double-buffering: during layer 3 SHOW, send frame A then frame B (B=~A) -> remainder of sweep still shows old frame; exactly one frame_swap; next sweep shows B.
- Simultaneous: frame_valid(C) on the frame_swap clk that commits B -> B displayed for the next sweep; C displayed after the following swap; two pulses total.
- en drop mid-SHOW of layer 5 -> next clk high_csn=FF, row_cs=0. Re-assert en -> BLANK layer 0 begins on the next tick.
- Async reset asserted mid-STROBE -> outputs return to reset values with no clock edge; the invariants (single layer low, no overlap with row_cs) are checked by assertion throughout all tests.
